mips_dmem_bus: RTL and testbench

- Data-side responder for the single-cycle MIPS core. It consumes the core's data-memory request (address, memwrite, writedata) and returns readdata in the same cycle.
- Decodes each request to either a word-addressed data RAM or a memory-mapped I/O page.
- The MMIO page holds a free-running cycle counter, a byte-wide transmit FIFO with a valid/ready drain port, and status bits.
- Sits beside the core at top level, between core and external console/peripheral logic.

---
 rtl/mips_dmem_bus.sv | 175 +++++++++++++++++
 tb/tb_mips_dmem_bus.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_bus.sv
// mips_dmem_bus: data-side responder for the single-cycle MIPS core.
// Decodes each data request to a word-addressed RAM or a memory-mapped I/O page
// (addr[31:16] == 16'hFFFF). The MMIO page holds a free-running cycle counter,
// a byte-wide transmit FIFO drained over a valid/ready port, and status bits.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   memwrite   core store strobe
//   addr       core byte address, bits [1:0] ignored
//   writedata  core store data
//   readdata   load data, combinational from addr
//   tx_data    FIFO head byte (0 while empty)
//   tx_valid   FIFO non-empty
//   tx_ready   consumer takes the head byte this cycle
//   irq        timer compare interrupt (only with MMIO_TIMER_IRQ_EN)
//
// Optional feature macro: MMIO_TIMER_IRQ_EN adds a COMPARE register at MMIO
// offset 0x000C and the sticky irq output.
//
// MMIO word offsets: 0x0 CYCLE, 0x4 TXDATA, 0x8 STATUS, 0xC COMPARE.
// STATUS = {16'h0, count[7:0], 4'h0, irq, overflow, full, empty}.
module mips_dmem_bus #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`ifdef MMIO_TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [13:0] OFF_CYCLE   = 14'd0;
  localparam logic [13:0] OFF_TXDATA  = 14'd1;
  localparam logic [13:0] OFF_STATUS  = 14'd2;
  localparam logic [13:0] OFF_COMPARE = 14'd3;

  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt,
                                              input logic irq_b,
                                              input logic ovf,
                                              input logic ful,
                                              input logic emp);
    logic [7:0] cnt8;
    cnt8 = 8'(cnt);
    return {16'h0000, cnt8, 4'h0, irq_b, ovf, ful, emp};
  endfunction

  // Address decode
  logic              is_mmio;
  logic [13:0]       word_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram, wr_cycle, wr_status, push_req;
  logic              unused_bits;

  assign is_mmio   = (addr[31:16] == 16'hFFFF);
  assign word_off  = addr[15:2];
  assign ram_idx   = addr[RAM_AW+1:2];
  assign wr_ram    = memwrite && !is_mmio;
  assign wr_cycle  = memwrite && is_mmio && (word_off == OFF_CYCLE);
  assign push_req  = memwrite && is_mmio && (word_off == OFF_TXDATA);
  assign wr_status = memwrite && is_mmio && (word_off == OFF_STATUS);
  assign unused_bits = &{1'b0, addr[1:0]};

  // Data RAM: combinational read, so a same-cycle write is seen one cycle later.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= writedata;
  end

  // Cycle counter: a write replaces that cycle's increment.
  logic [31:0] cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cycle <= 32'd0;
    else if (wr_cycle) cycle <= writedata;
    else               cycle <= cycle + 32'd1;
  end

  // Transmit FIFO
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               empty, full, pop, push, drop, overflow;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = !empty && tx_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  assign tx_valid = !empty;
  // Storage is not reset, so mask the head while empty to present 0.
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set wins over a same-cycle clear.
      if (drop)                         overflow <= 1'b1;
      else if (wr_status && writedata[2]) overflow <= 1'b0;
    end
  end

  // Optional compare timer
  logic        irq_flag;
  logic [31:0] compare_rd;

`ifdef MMIO_TIMER_IRQ_EN
  logic [31:0] compare;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      compare <= 32'd0;
      irq     <= 1'b0;
    end else begin
      if (memwrite && is_mmio && (word_off == OFF_COMPARE)) compare <= writedata;
      // Registered, sticky; a match outranks a same-cycle clear.
      if ((compare != 32'd0) && (cycle == compare)) irq <= 1'b1;
      else if (wr_status && writedata[3])           irq <= 1'b0;
    end
  end

  assign irq_flag   = irq;
  assign compare_rd = compare;
`else
  assign irq_flag   = 1'b0;
  assign compare_rd = 32'd0;
`endif

  // Read mux
  always_comb begin
    readdata = 32'd0;
    if (!is_mmio) begin
      readdata = ram[ram_idx];
    end else begin
      case (word_off)
        OFF_CYCLE:   readdata = cycle;
        OFF_STATUS:  readdata = status_word(count, irq_flag, overflow, full, empty);
        OFF_COMPARE: readdata = compare_rd;
        default:     readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_bus.sv
// Scoreboard bench for mips_dmem_bus. Stimulus pushes expected observations
// (readdata / tx_valid / tx_data / irq) and expected drained bytes into queues;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_dmem_bus;

  localparam logic [31:0] A_CYC = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef MMIO_TIMER_IRQ_EN
  logic        irq;
`endif

  mips_dmem_bus #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
`ifdef MMIO_TIMER_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: sel 0=readdata, 1=tx_valid, 2=tx_data, 3=irq
  string       name_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];
  logic [7:0]  tx_q[$];

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return readdata;
      1: return {31'd0, tx_valid};
      2: return {24'd0, tx_data};
`ifdef MMIO_TIMER_IRQ_EN
      3: return {31'd0, irq};
`endif
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %02h want no byte", tx_data);
      end else begin
        logic [7:0] eb;
        eb = tx_q.pop_front();
        if (tx_data !== eb) begin
          errors++;
          $display("FAIL tx_byte got %02h want %02h", tx_data, eb);
        end
      end
    end
    while (sel_q.size() > 0) begin
      string       n;
      int          s;
      logic [31:0] v;
      logic [31:0] got;
      n = name_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      got = observe(s);
      checks++;
      if (got !== v) begin
        errors++;
        $display("FAIL %s got %08h want %08h", n, got, v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input int s, input logic [31:0] v);
    name_q.push_back(n);
    sel_q.push_back(s);
    val_q.push_back(v);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic load(input string n, input logic [31:0] a, input logic [31:0] v);
    addr = a;
    memwrite = 1'b0;
    expect_val(n, 0, v);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    memwrite = 1'b0;
    addr = A_CYC;
    writedata = 32'd0;
    tx_ready = 1'b0;
    tick();

    // Reset state
    expect_val("rst_cycle", 0, 32'd0);
    expect_val("rst_tx_valid", 1, 32'd0);
    expect_val("rst_tx_data", 2, 32'd0);
`ifdef MMIO_TIMER_IRQ_EN
    expect_val("rst_irq", 3, 32'd0);
`endif
    tick();
    load("rst_status", A_ST, 32'h0000_0001);

    // Cycle counter counts rising edges after release
    reset = 1'b1;
    addr = A_CYC;
    repeat (7) tick();
    load("cycle_n", A_CYC, 32'd7);

    // RAM store/load, alias, read-during-write
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    load("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    store(32'h0000_0014, 32'h1111_1111);
    addr = 32'h0000_0014;
    writedata = 32'h2222_2222;
    memwrite = 1'b1;
    expect_val("ram_rdw_old", 0, 32'h1111_1111);
    tick();
    memwrite = 1'b0;
    load("ram_rdw_new", 32'h0000_0014, 32'h2222_2222);

    // Cycle load and wrap
    store(A_CYC, 32'hFFFF_FFFE);
    load("cycle_loaded", A_CYC, 32'hFFFF_FFFE);
    load("cycle_max", A_CYC, 32'hFFFF_FFFF);
    load("cycle_wrap", A_CYC, 32'h0000_0000);

    // Unused offsets and TXDATA read back 0
    store(32'hFFFF_0010, 32'h0000_1234);
    load("unmapped_rd", 32'hFFFF_0010, 32'd0);
    load("txdata_rd", A_TX, 32'd0);
`ifndef MMIO_TIMER_IRQ_EN
    load("compare_absent", A_CMP, 32'd0);
`endif

    // FIFO fill past full, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      store(A_TX, 32'h0000_0041 + i);
      if (i < 8) tx_q.push_back(8'(8'h41 + i));
    end
    load("status_full_ovf", A_ST, 32'h0000_0806);
    tx_ready = 1'b1;
    addr = A_ST;
    repeat (8) tick();
    expect_val("drained_tx_valid", 1, 32'd0);
    load("status_empty_ovf", A_ST, 32'h0000_0005);
    tx_ready = 1'b0;
    store(A_ST, 32'h0000_0004);
    load("status_ovf_clr", A_ST, 32'h0000_0001);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      store(A_TX, 32'h0000_0061 + i);
      tx_q.push_back(8'(8'h61 + i));
    end
    load("status_full", A_ST, 32'h0000_0802);
    tx_ready = 1'b1;
    tx_q.push_back(8'h5A);
    store(A_TX, 32'h0000_005A);
    tx_ready = 1'b0;
    load("status_full_pp", A_ST, 32'h0000_0802);
    tx_ready = 1'b1;
    repeat (8) tick();
    tx_ready = 1'b0;
    load("status_after_pp", A_ST, 32'h0000_0001);

    // Non-full simultaneous push and pop
    tx_q.push_back(8'h70);
    store(A_TX, 32'h0000_0070);
    tx_ready = 1'b1;
    tx_q.push_back(8'h71);
    store(A_TX, 32'h0000_0071);
    tx_ready = 1'b0;
    expect_val("one_tx_valid", 1, 32'd1);
    load("status_one", A_ST, 32'h0000_0100);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    load("status_one_drained", A_ST, 32'h0000_0001);

    // Asynchronous reset mid-operation
    store(A_TX, 32'h0000_0031);
    store(A_TX, 32'h0000_0032);
    store(A_TX, 32'h0000_0033);
    store(A_CYC, 32'd100);
    expect_val("pre_rst_tx_valid", 1, 32'd1);
    load("pre_rst_status", A_ST, 32'h0000_0300);
    addr = A_CYC;
    #1;
    reset = 1'b0;
    expect_val("async_tx_valid", 1, 32'd0);
    expect_val("async_tx_data", 2, 32'd0);
    expect_val("async_cycle", 0, 32'd0);
    tick();
    reset = 1'b1;
    load("ram_keeps", 32'h0000_0010, 32'hDEAD_BEEF);
    load("post_rst_status", A_ST, 32'h0000_0001);

`ifdef MMIO_TIMER_IRQ_EN
    // Timer compare interrupt
    store(A_CMP, 32'd20);
    load("compare_rb", A_CMP, 32'd20);
    store(A_CYC, 32'd0);
    repeat (20) tick();
    expect_val("irq_before", 3, 32'd0);
    load("cycle_at_cmp", A_CYC, 32'd20);
    expect_val("irq_set", 3, 32'd1);
    tick();
    repeat (5) tick();
    expect_val("irq_sticky", 3, 32'd1);
    load("status_irq", A_ST, 32'h0000_0009);
    store(A_ST, 32'h0000_0008);
    expect_val("irq_clr", 3, 32'd0);
    load("status_irq_clr", A_ST, 32'h0000_0001);
`endif

    tick();
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_leftover got %0d bytes want 0", tx_q.size());
    end
    checks++;
    if (sel_q.size() != 0) begin
      errors++;
      $display("FAIL checks_pending got %0d want 0", sel_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
